bcd_convert_seq: RTL and testbench
==================================

BCD_CONVERT_SEQ -- requirements
Module: bcd_convert_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the binary input width; legal range 4..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to convert bin.
REQ-005 The block SHALL have port bin, input, WIDTH bits: unsigned binary value, captured when start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse when a new result becomes valid.
REQ-008 The block SHALL have ports hundreds, tens and ones, each output, 4 bits: the registered BCD digits of the last completed conversion.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-010 In IDLE, with start=1 at a rising edge, the block SHALL capture bin into a shift register, clear the BCD scratch to 0, clear the bit counter to 0 and enter SHIFT.
REQ-011 In IDLE, with start=0, the block SHALL remain in IDLE with all outputs held.
REQ-012 Each SHIFT cycle SHALL apply this step: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one; the counter increments.
REQ-013 After exactly WIDTH SHIFT cycles the block SHALL enter DONE.
REQ-014 In DONE the block SHALL load hundreds/tens/ones from the scratch, assert done for that one cycle, and return to IDLE on the next edge.
REQ-015 Latency SHALL be fixed at WIDTH+1 cycles from the accepting edge to the edge that asserts done (start accepted at edge 0 -> done high after edge WIDTH+1).
REQ-016 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-017 A start in SHIFT or DONE SHALL be ignored: not queued, no effect on the result.
REQ-018 Changes on bin after acceptance SHALL NOT affect the conversion in progress.
REQ-019 hundreds/tens/ones SHALL change only on the DONE cycle and hold between conversions.
REQ-020 Every digit SHALL be in the range 0..9; for WIDTH < 8, hundreds SHALL be 0 except where the value requires it (never for WIDTH <= 6).
REQ-021 A start asserted in the cycle where the FSM returns to IDLE (DONE -> IDLE edge) SHALL be ignored; the earliest next acceptance is the following edge, so back-to-back throughput is one conversion per WIDTH+2 cycles.
REQ-022 Scratch register width SHALL be 12 bits (3 digits); the shift register width SHALL be WIDTH.

Reset
REQ-023 With clr=0 at a rising edge, the block SHALL enter IDLE and force busy=0, done=0, hundreds=tens=ones=0, counter=0 and scratch=0.
REQ-024 A reset during SHIFT or DONE SHALL abort the conversion: no done pulse, and the previous result is lost (digits zero).
REQ-025 If clr=0 and start=1 occur together, reset SHALL win.
REQ-026 On the first edge after clr returns to 1, the block SHALL accept start normally.

Structure
REQ-027 The state encoding (IDLE/SHIFT/DONE) and the constants DIGITS=3 and ADJ=3 SHALL be placed in a shared package so the display stage can reuse them.
REQ-028 The per-digit "if >= 5 add 3" adjust SHALL be a combinational sub-module named bcd_add3, instantiated three times.
REQ-029 The block SHALL sit between the gcd result and the seven-segment driver, taking its start from a level-change or go pulse generated upstream.

Verification
REQ-030 The bench SHALL cover: WIDTH=8, bin=0, start pulse -> busy for 9 cycles, done pulse at edge 9, digits 0/0/0.
REQ-031 The bench SHALL cover: WIDTH=8, bin=255 -> digits 2/5/5 with done; then bin=100 -> 1/0/0, with outputs holding 2/5/5 until that done.
REQ-032 The bench SHALL cover: WIDTH=4, bin=9 -> 0/0/9 and bin=15 -> 0/1/5, each with done at edge 5.
REQ-033 The bench SHALL cover: WIDTH=8, bin=37 accepted, then start with bin=200 at edge 3 -> result 0/3/7, exactly one done pulse.
REQ-034 The bench SHALL cover: WIDTH=8, bin=128 accepted, clr=0 at edge 4 -> no done, digits 0/0/0, busy=0; then a new start with bin=42 -> 0/4/2.
REQ-035 The bench SHALL cover: start held high continuously with bin=99 -> repeated conversions every 10 cycles, each giving 0/9/9.

Source files
------------

// File: rtl/bcd_convert_seq_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   state_t   : converter FSM encoding (IDLE / SHIFT / DONE)
//   DIGITS    : number of BCD digits held in the scratch register
//   ADJ       : value added to a digit >= 5 before each shift
//   SCRATCH_W : scratch register width in bits
package bcd_convert_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int         DIGITS    = 3;
   localparam logic [3:0] ADJ       = 4'd3;
   localparam int         SCRATCH_W = 4 * DIGITS;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets ADJ added so the
// following left shift carries correctly into the next decade.
// Latency: combinational. Backpressure: none.
//   digit    : current BCD scratch digit (0..9)
//   adjusted : digit, or digit + ADJ when digit >= 5
module bcd_add3
   import bcd_convert_seq_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   // Inputs stay within 0..9, so the result never exceeds 12 and fits 4 bits.
   always_comb begin
      adjusted = digit;
      if (digit >= 4'd5) begin
         adjusted = digit + ADJ;
      end
   end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Latency: WIDTH+1 cycles from the accepting edge to the edge raising done.
// Backpressure: start is only honoured in IDLE; starts while busy are dropped.
//   clk      : clock, all state on rising edge
//   clr      : synchronous active-low reset
//   start    : single-cycle conversion request, bin captured when accepted
//   bin      : unsigned binary input, WIDTH bits (legal WIDTH 4..8)
//   busy     : high in SHIFT and DONE
//   done     : one-cycle pulse when hundreds/tens/ones take a new result
//   hundreds/tens/ones : registered BCD digits of the last finished conversion
module bcd_convert_seq
   import bcd_convert_seq_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [3:0]       hundreds,
   output logic [3:0]       tens,
   output logic [3:0]       ones
);

   state_t                     state;
   logic [WIDTH-1:0]           shreg;
   logic [SCRATCH_W-1:0]       scratch;
   logic [SCRATCH_W-1:0]       adjusted;
   logic [3:0]                 cnt;
   logic [SCRATCH_W+WIDTH-1:0] shifted;

   // One corrector per digit, all working on the current scratch value.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_add3 u_add3 (
         .digit    (scratch[4*g +: 4]),
         .adjusted (adjusted[4*g +: 4])
      );
   end

   // Corrected scratch and the remaining binary bits move left as one word;
   // the MSB of shreg enters the ones digit.
   assign shifted = {adjusted, shreg} << 1;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hundreds <= '0;
         tens     <= '0;
         ones     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  shreg   <= bin;
                  scratch <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scratch <= shifted[SCRATCH_W+WIDTH-1:WIDTH];
               shreg   <= shifted[WIDTH-1:0];
               cnt     <= cnt + 4'd1;
               // cnt counts completed shifts; this edge performs the last one.
               if (cnt == 4'(WIDTH - 1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               hundreds <= scratch[8 +: 4];
               tens     <= scratch[4 +: 4];
               ones     <= scratch[0 +: 4];
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Bench for bcd_convert_seq: a WIDTH=8 and a WIDTH=4 instance on one clock,
// expected digits from decimal arithmetic on the input value.
module tb_bcd_convert_seq;

   logic       clk = 1'b0;
   logic       clr8, start8, clr4, start4;
   logic [7:0] bin8;
   logic [3:0] bin4;
   logic       busy8, done8, busy4, done4;
   logic [3:0] h8, t8, o8, h4, t4, o4;

   int         checks = 0;
   int         errors = 0;
   logic [11:0] last [2];   // index 1: WIDTH=8 instance, 0: WIDTH=4 instance

   always #5 clk = ~clk;

   bcd_convert_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .clr(clr8), .start(start8), .bin(bin8),
      .busy(busy8), .done(done8), .hundreds(h8), .tens(t8), .ones(o8)
   );

   bcd_convert_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .clr(clr4), .start(start4), .bin(bin4),
      .busy(busy4), .done(done4), .hundreds(h4), .tens(t4), .ones(o4)
   );

   function automatic logic [11:0] ref_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // {busy, done, hundreds, tens, ones}
   function automatic logic [13:0] obs(input bit w8);
      return w8 ? {busy8, done8, h8, t8, o8} : {busy4, done4, h4, t4, o4};
   endfunction

   task automatic drive(input bit w8, input logic s, input int b);
      if (w8) begin
         start8 = s;
         bin8   = 8'(b);
      end else begin
         start4 = s;
         bin4   = 4'(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic chk_state(input bit w8, input logic b, input logic d, input logic [11:0] dig);
      logic [13:0] o;
      o = obs(w8);
      chk(w8 ? "busy8" : "busy4", 12'(o[13]), 12'(b));
      chk(w8 ? "done8" : "done4", 12'(o[12]), 12'(d));
      chk(w8 ? "digits8" : "digits4", o[11:0], dig);
   endtask

   // mode 0: start dropped after acceptance; 1: random start/bin noise while
   // busy; 2: stray start with bin=200 at edge 3. bin is scrambled in all modes.
   task automatic conv(input bit w8, input int v, input int mode);
      int          n;
      int          maxv;
      logic [11:0] want;
      n    = w8 ? 8 : 4;
      maxv = w8 ? 255 : 15;
      want = ref_bcd(v);
      drive(w8, 1'b1, v);
      tick();                                   // edge 0: accepted
      chk_state(w8, 1'b1, 1'b0, last[w8]);
      for (int e = 1; e <= n + 1; e++) begin
         case (mode)
            1:       drive(w8, 1'($urandom_range(0, 1)), int'($urandom_range(0, maxv)));
            2:       drive(w8, e == 3, (e == 3) ? 200 : int'($urandom_range(0, maxv)));
            default: drive(w8, 1'b0, int'($urandom_range(0, maxv)));
         endcase
         tick();
         if (e <= n) chk_state(w8, 1'b1, 1'b0, last[w8]);
         else        chk_state(w8, 1'b0, 1'b1, want);
      end
      drive(w8, 1'b0, 0);
      tick();
      chk_state(w8, 1'b0, 1'b0, want);
      last[w8] = want;
   endtask

   initial begin
      last[0] = '0;
      last[1] = '0;

      // Reset held with start asserted: reset must win.
      clr8 = 1'b0; clr4 = 1'b0;
      drive(1'b1, 1'b1, 77);
      drive(1'b0, 1'b1, 5);
      tick();
      tick();
      chk_state(1'b1, 1'b0, 1'b0, 12'h000);
      chk_state(1'b0, 1'b0, 1'b0, 12'h000);

      // Start presented on the very first edge with clr released.
      drive(1'b0, 1'b0, 0);
      clr8 = 1'b1; clr4 = 1'b1;
      conv(1'b1, 0, 0);
      conv(1'b1, 255, 0);
      conv(1'b1, 100, 0);

      conv(1'b0, 9, 0);
      conv(1'b0, 15, 0);

      conv(1'b1, 37, 2);

      // Abort by reset in the middle of SHIFT.
      drive(1'b1, 1'b1, 128);
      tick();                                   // edge 0
      drive(1'b1, 1'b0, 0);
      for (int e = 1; e <= 3; e++) tick();
      clr8 = 1'b0;
      tick();                                   // edge 4
      clr8 = 1'b1;
      chk_state(1'b1, 1'b0, 1'b0, 12'h000);
      last[1] = '0;
      for (int e = 0; e < 10; e++) begin
         tick();
         chk_state(1'b1, 1'b0, 1'b0, 12'h000);
      end
      conv(1'b1, 42, 0);

      // Start held high: a new conversion every WIDTH+2 cycles.
      drive(1'b1, 1'b1, 99);
      for (int k = 0; k < 30; k++) begin
         tick();
         chk_state(1'b1, (k % 10) != 9, (k % 10) == 9,
                   (k < 9) ? last[1] : 12'h099);
      end
      drive(1'b1, 1'b0, 0);
      tick();
      chk_state(1'b1, 1'b0, 1'b0, 12'h099);
      last[1] = 12'h099;

      // Randomized values with noise on start/bin while busy.
      for (int i = 0; i < 8; i++) conv(1'b1, int'($urandom_range(0, 255)), 1);
      for (int i = 0; i < 6; i++) conv(1'b0, int'($urandom_range(0, 15)), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
